hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage RV32I pipeline.
- Keeps the existing duties: load-use stall, branch/jump flush, and EX-operand forwarding from MEM/WB.
- Generalises the number of source operands.
- Adds a sequential multi-cycle execute controller (MUL/DIV style): it holds the EX instruction for MC_CYCLES cycles and injects bubbles into MEM.

Parameters:
- NUM_RS, 2, source register operands per instruction (1..3).
- REG_AW, 5, register address width.
- MC_CYCLES, 4, total EX occupancy of a multi-cycle op (1..16); 1 disables the controller.
- CNT_W, 4, multi-cycle counter width; must hold MC_CYCLES-2.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- RsD  input  NUM_RS*REG_AW  packed source addresses in Decode; operand i at [i*REG_AW +: REG_AW].
- RsE  input  NUM_RS*REG_AW  packed source addresses in Execute.
- RdE, RdM, RdW  input  REG_AW each  destination addresses in E, M, W.
- RegWriteM, RegWriteW  input  1 each  write-enable in M, W.
- ResultSrcE  input  2  result source in E; 2'b01 marks a load.
- PCSrcE  input  1  taken branch/jump resolved in E.
- McStartE  input  1  the instruction in E is a multi-cycle op.
- StallF, StallD, StallE  output  1 each  hold the F, D, E pipeline registers.
- FlushD, FlushE, FlushM  output  1 each  bubble into the D, E, M pipeline registers.
- ForwardE  output  NUM_RS*2  per-operand select: 00 register file, 01 W, 10 M.
- McBusy  output  1  multi-cycle op is occupying E (registered state != IDLE).

Behaviour:
- Reset (async, high):
  - state=IDLE, cnt=0.
  - All stall/flush outputs are 0 while reset is high.
  - ForwardE stays combinational.
- Forwarding, per operand i, purely combinational:
  - 10 if RsE[i]!=0, RsE[i]==RdM and RegWriteM.
  - Else 01 if RsE[i]!=0, RsE[i]==RdW and RegWriteW.
  - Else 00.
  - M has priority over W.
- lwStall = ResultSrcE==2'b01 and RdE!=0 and any RsD[i]==RdE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - If McStartE and !PCSrcE and MC_CYCLES>1: start. Load cnt=MC_CYCLES-2; go to BUSY if cnt>0, else to DONE.
    - Otherwise stay.
  - BUSY:
    - cnt decrements by 1 per cycle.
    - When cnt==1, go to DONE (cnt becomes 0).
    - McStartE is ignored.
  - DONE:
    - The op advances out of E this cycle.
    - Always go to IDLE; McStartE is ignored here, so the held op cannot retrigger.
- mcStall = (IDLE and start condition) or BUSY.
  - mcStall is high for exactly MC_CYCLES-1 consecutive cycles, beginning the first cycle the op is in E.
  - The op occupies E for MC_CYCLES cycles.
- Output equations:
  - StallF = StallD = mcStall or lwStall.
  - StallE = mcStall.
  - FlushM = mcStall.
  - FlushE = !mcStall and (lwStall or PCSrcE).
  - FlushD = !mcStall and PCSrcE.
- Simultaneous events:
  - PCSrcE with McStartE in IDLE: the flush wins and no start occurs.
  - PCSrcE during BUSY: illegal by construction; it is masked.
  - lwStall during mcStall: the E flush is suppressed and D/F stay held. The load-use check re-evaluates after release.
- A back-to-back multi-cycle op enters E the cycle after DONE and starts normally from IDLE.
- Reset mid-operation returns to IDLE immediately; stalls drop asynchronously.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs StallCycles[31:0] and FlushCycles[31:0], both reset to 0.
  - StallCycles increments each clock where StallF=1.
  - FlushCycles increments each clock where FlushD or FlushE is 1.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_LOAD=2'b01.
  - The mc_state_t enum (IDLE, BUSY, DONE).
- One natural sub-module: hazard_mc_ctrl, the FSM plus counter, producing mcStall and McBusy.
- Forwarding and load-use logic are generated per operand inside the top level.

Test Plan:
- Forwarding priority: RsE[0]=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardE[1:0]=10. Then RegWriteM=0 -> 01. Then RsE[0]=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, RsD[1]=7 -> StallF=StallD=FlushE=1, StallE=0. Repeat with RdE=0 -> all 0.
- Multi-cycle, MC_CYCLES=4: McStartE held 4 cycles -> StallE/FlushM=1 on cycles 0-2, 0 on cycle 3; McBusy=1 on cycles 1-3; no retrigger.
- Branch versus start: PCSrcE=1 and McStartE=1 in IDLE -> FlushD=FlushE=1, StallE=0, state stays IDLE.
- Reset mid-op: reset asserted in BUSY cycle 1 -> all stalls 0 within the same cycle; after release McStartE=1 starts a fresh MC_CYCLES-1 stall.
- HAZARD_PERF_EN: 3-cycle multi-cycle stall plus 1 branch flush -> StallCycles=3, FlushCycles=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and forwarding helper for the RV32I hazard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // MEM wins over WB because it holds the younger value of the same register.
  function automatic logic [1:0] fwdSelect(input logic rsValid,
                                           input logic hitM,
                                           input logic hitW);
    if (rsValid && hitM) return FWD_MEM;
    if (rsValid && hitW) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mc_ctrl.sv
// Multi-cycle execute controller: holds the EX instruction for MC_CYCLES cycles.
// mcState is exported so checkers can observe the FSM directly.
module hazard_mc_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      McStartE,
  input  logic      PCSrcE,
  output logic      mcStall,
  output logic      McBusy,
  output mc_state_t mcState
);

  localparam int              LOAD_VAL = (MC_CYCLES > 1) ? MC_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);
  localparam bit              MC_EN    = (MC_CYCLES > 1);

  mc_state_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             startOk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    startOk   = 1'b0;
    case (state)
      IDLE: begin
        // A taken branch kills the op in E, so it must not start.
        if (McStartE && !PCSrcE && MC_EN) begin
          startOk   = 1'b1;
          cntNext   = CNT_LOAD;
          stateNext = (CNT_LOAD != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          stateNext = DONE;
          cntNext   = '0;
        end
      end
      DONE: begin
        // The held op leaves E now; its McStartE must not retrigger.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign mcStall = startOk || (state == BUSY);
  assign McBusy  = (state != IDLE);
  assign mcState = state;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: load-use stall, branch flush, MEM/WB forwarding and multi-cycle EX hold.
// Define HAZARD_PERF_EN to add the StallCycles/FlushCycles performance counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NUM_RS    = 2,
  parameter int REG_AW    = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RS*REG_AW-1:0] RsD,
  input  logic [NUM_RS*REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0]        RdE,
  input  logic [REG_AW-1:0]        RdM,
  input  logic [REG_AW-1:0]        RdW,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic [1:0]               ResultSrcE,
  input  logic                     PCSrcE,
  input  logic                     McStartE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushM,
  output logic [NUM_RS*2-1:0]      ForwardE,
  output logic                     McBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]              StallCycles,
  output logic [31:0]              FlushCycles
`endif
);

  logic [NUM_RS-1:0] lwHit;
  logic              lwStall;
  logic              mcStall;
  mc_state_t         mcState;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_op
    logic [REG_AW-1:0] rsE;
    logic [REG_AW-1:0] rsD;
    assign rsE = RsE[i*REG_AW +: REG_AW];
    assign rsD = RsD[i*REG_AW +: REG_AW];
    assign ForwardE[i*2 +: 2] = fwdSelect(rsE != '0,
                                          (rsE == RdM) && RegWriteM,
                                          (rsE == RdW) && RegWriteW);
    assign lwHit[i] = (rsD == RdE);
  end

  assign lwStall = (ResultSrcE == RES_LOAD) && (RdE != '0) && (|lwHit);

  hazard_mc_ctrl #(
    .MC_CYCLES(MC_CYCLES),
    .CNT_W    (CNT_W)
  ) u_mc_ctrl (
    .clk     (clk),
    .reset   (reset),
    .McStartE(McStartE),
    .PCSrcE  (PCSrcE),
    .mcStall (mcStall),
    .McBusy  (McBusy),
    .mcState (mcState)
  );

  // Gating with reset makes every stall/flush drop asynchronously on reset.
  assign StallF = !reset && (mcStall || lwStall);
  assign StallD = !reset && (mcStall || lwStall);
  assign StallE = !reset && mcStall;
  assign FlushM = !reset && mcStall;
  assign FlushE = !reset && !mcStall && (lwStall || PCSrcE);
  assign FlushD = !reset && !mcStall && PCSrcE;

  busyHoldsE: assert property (@(posedge clk) disable iff (reset)
                               (mcState == BUSY) |-> mcStall);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (StallF) StallCycles <= StallCycles + 32'd1;
      if (FlushD || FlushE) FlushCycles <= FlushCycles + 32'd1;
    end
  end
`endif

endmodule
